// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg
// Shared definitions for the iterative execute-stage ALU:
//   op_t          - 4-bit operation code map (all sixteen codes used)
//   state_t       - control FSM states (IDLE, MUL, DIV, DONE)
//   is_multicycle - op runs through the shift-add / restoring-divide unit
//   is_divide     - op uses the divide iteration (DIVU, REMU)
package alu_iter_pkg;

    // ANDN gave up its code to REMU so that the whole map fits in four bits.
    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_REMU  = 4'h5,
        OP_SEQ   = 4'h6,
        OP_SLT   = 4'h7,
        OP_SLE   = 4'h8,
        OP_SCO   = 4'h9,
        OP_BTR   = 4'hA,
        OP_PASSB = 4'hB,
        OP_SLBI  = 4'hC,
        OP_MULLO = 4'hD,
        OP_MULHI = 4'hE,
        OP_DIVU  = 4'hF
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_multicycle(input op_t op);
        return (op == OP_MULLO) || (op == OP_MULHI) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_divide(input op_t op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if
// Request/response bundle between issue, the ALU and the memory stage.
//   master : in_valid, op, a, b, out_ready  ->   (issue / consumer side)
//            in_ready, out_valid, result, ofl, div_zero, busy  <-
//   slave  : the ALU side, directions mirrored.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer that raised valid keeps valid and its payload stable
// until that edge; ready may depend combinationally on the other side's
// ready (in_ready follows out_ready) but never on valid.
interface alu_iter_if #(
    parameter int WIDTH = 16
);
    import alu_iter_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ofl;
    logic             div_zero;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, ofl, div_zero, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, ofl, div_zero, busy
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv
// Shared iteration engine for unsigned multiply (shift-add) and unsigned
// restoring divide. One register pair {hi, lo} serves both:
//   multiply: hi = partial product, lo = multiplier shifting out / product low
//   divide  : hi = partial remainder, lo = dividend shifting out / quotient
// Ports:
//   clk, rst       clock, async active-high reset
//   i_start        strobe: load operands and perform the first iteration
//   i_is_div       1 = divide iteration, 0 = multiply iteration
//   i_a, i_b       operands (multiplicand/multiplier, dividend/divisor)
//   o_last         strobe: the final iteration is written on this edge
//   o_hi, o_lo     product high/low, or remainder/quotient
module alu_iter_muldiv #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;
    logic             r_is_div;
    logic [CNT_W-1:0] r_cnt;

    logic             w_step;
    logic [WIDTH-1:0] w_src_hi;
    logic [WIDTH-1:0] w_src_lo;
    logic [WIDTH-1:0] w_src_b;
    logic             w_src_div;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;

    // The load edge already performs iteration 1 straight from the operand
    // inputs, so WIDTH iterations finish while the counter runs WIDTH..2 and
    // the counter sits at 1 during the DONE cycle without stepping.
    assign w_step    = i_start || (r_cnt > CNT_W'(1));
    assign w_src_hi  = i_start ? '0       : r_hi;
    assign w_src_lo  = i_start ? i_a      : r_lo;
    assign w_src_b   = i_start ? i_b      : r_opb;
    assign w_src_div = i_start ? i_is_div : r_is_div;

    assign w_mul_sum = {1'b0, w_src_hi} + (w_src_lo[0] ? {1'b0, w_src_b} : '0);

    // With a zero divisor every trial subtraction succeeds, so the quotient
    // fills with ones and the dividend shifts unchanged into the remainder:
    // that is exactly the all-ones / a result wanted for divide-by-zero.
    assign w_div_shift = {w_src_hi, w_src_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, w_src_b});
    assign w_div_rem   = w_div_ge ? WIDTH'(w_div_shift - {1'b0, w_src_b})
                                  : w_div_shift[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_start) begin
                r_opb    <= i_b;
                r_is_div <= i_is_div;
                r_cnt    <= CNT_W'(WIDTH);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_step) begin
                if (w_src_div) begin
                    r_hi <= w_div_rem;
                    r_lo <= {w_src_lo[WIDTH-2:0], w_div_ge};
                end else begin
                    {r_hi, r_lo} <= {w_mul_sum, w_src_lo[WIDTH-1:1]};
                end
            end
        end
    end

    // Counter moving 2 -> 1 marks the edge that writes the last iteration.
    assign o_last = !i_start && (r_cnt == CNT_W'(2));
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_iter.sv
// alu_iter
// Execute-stage ALU with a valid/ready request port, a registered result and
// an iterative multiply/divide path that stalls issue while it runs.
// Ports:
//   clk, rst      clock, async active-high reset
//   bus (slave)   in_valid/in_ready/op/a/b request, out_valid/out_ready/
//                 result/ofl/div_zero response, busy status
//   o_dbg_state   current control FSM state
// Single-cycle ops are computed inline and registered on accept (result
// visible the following cycle). Multi-cycle ops go IDLE -> MUL/DIV -> DONE
// -> IDLE, giving out_valid WIDTH+1 cycles after accept.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    alu_iter_if.slave    bus,
    output state_t       o_dbg_state
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] LOW8_MASK = WIDTH'(8'hFF);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_ofl;
    logic             r_div_zero;
    op_t              r_mc_op;
    logic             r_mc_dz;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_start;
    logic             w_md_last;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rev;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_ofl;
    logic [WIDTH-1:0] w_mc_result;

    // Ready depends on out_ready so a consumed result can be refilled by a
    // new single-cycle op on the very same edge.
    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_start    = w_accept && is_multicycle(bus.op);

    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = bus.a - bus.b;

    always_comb begin : bit_reverse
        w_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rev[i] = bus.a[WIDTH-1-i];
        end
    end

    // Undefined or multi-cycle codes fall to PASSB here; the multi-cycle
    // ones never reach the result register through this path.
    always_comb begin : single_cycle
        w_sc_result = bus.b;
        w_sc_ofl    = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_ofl    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_result = w_diff;
                w_sc_ofl    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  w_sc_result = bus.a & bus.b;
            OP_OR:   w_sc_result = bus.a | bus.b;
            OP_XOR:  w_sc_result = bus.a ^ bus.b;
            OP_SEQ:  w_sc_result = WIDTH'(bus.a == bus.b);
            // True signed compares: no subtraction, so no overflow hazard.
            OP_SLT:  w_sc_result = WIDTH'($signed(bus.a) <  $signed(bus.b));
            OP_SLE:  w_sc_result = WIDTH'($signed(bus.a) <= $signed(bus.b));
            OP_SCO:  w_sc_result = WIDTH'(w_sum[WIDTH]);
            OP_BTR:  w_sc_result = w_rev;
            OP_SLBI: w_sc_result = (bus.a << 8) | (bus.b & LOW8_MASK);
            default: w_sc_result = bus.b;
        endcase
    end

    always_comb begin : mc_select
        w_mc_result = w_md_hi;
        case (r_mc_op)
            OP_MULLO: w_mc_result = w_md_lo;
            OP_MULHI: w_mc_result = w_md_hi;
            OP_DIVU:  w_mc_result = w_md_lo;
            default:  w_mc_result = w_md_hi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : next_state
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = is_divide(bus.op) ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (w_md_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ofl       <= 1'b0;
            r_div_zero  <= 1'b0;
            r_mc_op     <= OP_ADD;
            r_mc_dz     <= 1'b0;
        end else begin
            if (w_start) begin
                r_mc_op <= bus.op;
                r_mc_dz <= is_divide(bus.op) && (bus.b == '0);
            end

            if (w_accept && !is_multicycle(bus.op)) begin
                r_result    <= w_sc_result;
                r_ofl       <= w_sc_ofl;
                r_div_zero  <= 1'b0;
                r_out_valid <= 1'b1;
            end else if (r_state == ST_DONE) begin
                // Output is always free here: a multi-cycle op is only
                // accepted once the previous result has been consumed.
                r_result    <= w_mc_result;
                r_ofl       <= 1'b0;
                r_div_zero  <= r_mc_dz;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_is_div (is_divide(bus.op)),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_last   (w_md_last),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    // busy covers the iteration cycles and DONE; it drops on the same edge
    // that raises out_valid.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.ofl       = r_ofl;
    assign bus.div_zero  = r_div_zero;
    assign bus.busy      = (r_state != ST_IDLE);
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;
    import alu_iter_pkg::*;

    localparam int W      = 16;
    localparam int N_RAND = 40;
    localparam int N_STRM = 200;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // {ofl, div_zero, result}
    logic [W+1:0] exp_q[$];

    alu_iter_if #(.WIDTH(W)) bus ();

    alu_iter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic logic [W+1:0] model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        int          sa;
        int          sb;
        int          s;
        logic [31:0] p;
        logic [W-1:0] r;
        logic         o;
        logic         z;
        sa = $signed(a);
        sb = $signed(b);
        o  = 1'b0;
        z  = 1'b0;
        r  = b;
        p  = 32'(a) * 32'(b);
        case (op)
            OP_ADD:   begin s = sa + sb; r = a + b; o = (s > 32767) || (s < -32768); end
            OP_SUB:   begin s = sa - sb; r = a - b; o = (s > 32767) || (s < -32768); end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SEQ:   r = (a == b) ? 1 : 0;
            OP_SLT:   r = (sa < sb) ? 1 : 0;
            OP_SLE:   r = (sa <= sb) ? 1 : 0;
            OP_SCO:   r = ((32'(a) + 32'(b)) > 32'd65535) ? 1 : 0;
            OP_BTR:   r = {<<{a}};
            OP_PASSB: r = b;
            OP_SLBI:  r = W'((32'(a) << 8) | (32'(b) & 32'd255));
            OP_MULLO: r = p[15:0];
            OP_MULHI: r = p[31:16];
            OP_DIVU:  begin z = (b == 0); r = z ? 16'hFFFF : a / b; end
            OP_REMU:  begin z = (b == 0); r = z ? a : a % b; end
            default:  r = b;
        endcase
        return {o, z, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated op with out_ready high: checks accept, latency, busy/stall
    // window, payload, and that the result is consumed afterwards.
    task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W+1:0] exp);
        int cyc;
        int busy_cyc;
        int rdy_cyc;
        int lat;
        lat = is_multicycle(op) ? W + 1 : 1;
        exp_q.push_back(exp);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b1;
        #1;
        check("accept_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        cyc      = 1;
        busy_cyc = 0;
        rdy_cyc  = 0;
        while (!bus.out_valid && cyc < 4 * W) begin
            if (bus.busy) busy_cyc++;
            if (bus.in_ready) rdy_cyc++;
            step();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("busy_cycles", 32'(busy_cyc), 32'(lat - 1));
        check("stall_ready", 32'(rdy_cyc), 0);
        check("result", 32'({bus.ofl, bus.div_zero, bus.result}), 32'(exp_q.pop_front()));
        step();
        check("drained", 32'(bus.out_valid), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W+1:0] held;
        logic         hold_active;
        logic         hs_out;
        logic         acc;
        int           issued;
        int           done;
        int           cyc;
        op_t          rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check("rst_outputs", 32'({bus.out_valid, bus.busy, bus.ofl, bus.div_zero, bus.result}), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        step();
        check("idle_in_ready", 32'(bus.in_ready), 1);

        // Arithmetic with overflow, compares, bit ops
        run_op(OP_ADD,   16'h7FFF, 16'h0001, {2'b10, 16'h8000});
        run_op(OP_SUB,   16'h8000, 16'h0001, {2'b10, 16'h7FFF});
        run_op(OP_ADD,   16'hFFFF, 16'h0001, {2'b00, 16'h0000});
        run_op(OP_SLT,   16'h8000, 16'h7FFF, {2'b00, 16'h0001});
        run_op(OP_SLE,   16'h7FFF, 16'h8000, {2'b00, 16'h0000});
        run_op(OP_SLE,   16'h8000, 16'h8000, {2'b00, 16'h0001});
        run_op(OP_SEQ,   16'h1234, 16'h1234, {2'b00, 16'h0001});
        run_op(OP_SCO,   16'hFFFF, 16'h0001, {2'b00, 16'h0001});
        run_op(OP_BTR,   16'h0001, 16'h0000, {2'b00, 16'h8000});
        run_op(OP_SLBI,  16'h00AB, 16'h12CD, {2'b00, 16'hABCD});
        run_op(OP_PASSB, 16'h1111, 16'h5A5A, {2'b00, 16'h5A5A});

        // Multiply / divide including divide-by-zero
        run_op(OP_MULHI, 16'hFFFF, 16'hFFFF, {2'b00, 16'hFFFE});
        run_op(OP_MULLO, 16'hFFFF, 16'hFFFF, {2'b00, 16'h0001});
        run_op(OP_DIVU,  16'h00C8, 16'h0007, {2'b00, 16'h001C});
        run_op(OP_REMU,  16'h00C8, 16'h0007, {2'b00, 16'h0004});
        run_op(OP_DIVU,  16'h1234, 16'h0000, {2'b01, 16'hFFFF});
        run_op(OP_REMU,  16'h1234, 16'h0000, {2'b01, 16'h1234});

        // Random isolated ops against the model
        for (int i = 0; i < N_RAND; i++) begin
            rop = op_t'($urandom_range(0, 15));
            ra  = W'($urandom);
            rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_op(rop, ra, rb, model(rop, ra, rb));
        end

        // Back-pressure: result held while out_ready low, refill on release
        bus.in_valid  = 1'b1;
        bus.op        = OP_ADD;
        bus.a         = 16'h0001;
        bus.b         = 16'h0002;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'({bus.out_valid, bus.ofl, bus.div_zero, bus.result}),
                  32'({1'b1, 2'b00, 16'h0003}));
            check("bp_in_ready", 32'(bus.in_ready), 0);
            step();
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = OP_XOR;
        bus.a         = 16'h00FF;
        bus.b         = 16'h0F0F;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 1);
        step();
        bus.in_valid = 1'b0;
        check("bp_refill", 32'({bus.out_valid, bus.result}), 32'({1'b1, 16'h0FF0}));
        step();
        check("bp_drained", 32'(bus.out_valid), 0);

        // Reset in the middle of a divide
        bus.in_valid = 1'b1;
        bus.op       = OP_DIVU;
        bus.a        = 16'hBEEF;
        bus.b        = 16'h0013;
        step();
        bus.in_valid = 1'b0;
        repeat (7) step();
        check("mid_busy", 32'(bus.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'({bus.out_valid, bus.busy, bus.ofl, bus.div_zero, bus.result}), 0);
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) step();
        check("abort_no_result", 32'(bus.out_valid), 0);
        run_op(OP_ADD, 16'h0002, 16'h0003, {2'b00, 16'h0005});

        // Streaming: back-to-back requests, random back-pressure, scoreboard
        issued      = 0;
        done        = 0;
        cyc         = 0;
        hold_active = 1'b0;
        held        = '0;
        bus.in_valid = 1'b1;
        bus.op       = op_t'($urandom_range(0, 15));
        bus.a        = W'($urandom);
        bus.b        = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        bus.out_ready = 1'b1;
        while (done < N_STRM && cyc < 30000) begin
            @(negedge clk);
            if (hold_active) begin
                check("strm_hold", 32'({bus.out_valid, bus.ofl, bus.div_zero, bus.result}),
                      32'({1'b1, held}));
            end
            hs_out = bus.out_valid && bus.out_ready;
            acc    = bus.in_valid && bus.in_ready;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    check("strm_unexpected", 32'(bus.result), 32'hDEAD_0000);
                end else begin
                    check("strm_result", 32'({bus.ofl, bus.div_zero, bus.result}),
                          32'(exp_q.pop_front()));
                end
                done++;
            end
            hold_active = bus.out_valid && !bus.out_ready;
            held        = {bus.ofl, bus.div_zero, bus.result};
            if (acc) begin
                exp_q.push_back(model(bus.op, bus.a, bus.b));
                issued++;
            end
            step();
            cyc++;
            if (acc) begin
                if (issued < N_STRM) begin
                    bus.op = op_t'($urandom_range(0, 15));
                    bus.a  = W'($urandom);
                    bus.b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        check("strm_count", 32'(done), 32'(N_STRM));
        check("strm_queue_empty", 32'(exp_q.size()), 0);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
